inst_fetch_arbiter: RTL and testbench
=====================================

Name: inst_fetch_arbiter

Overview:
- Shares one instruction-memory fetch port between the way0 and way1 instruction fetch units (IFUs).
- Sits between the per-way IFU request/dataOk interfaces and the single memory-side fetch bus.
- Arbitration is round-robin, with one outstanding transaction at a time.
- A pipeline jump flushes the in-flight fetch: its response is drained and discarded.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
way0_request_i  in  1  way0 fetch request; held until way0_dataOk_o
way0_instAddr_i  in  ADDR_W  way0 fetch address; stable while request is high
way0_dataOk_o  out  1  one-cycle pulse: way0_inst_o is valid
way0_inst_o  out  DATA_W  fetched instruction for way0
way1_request_i  in  1  way1 fetch request
way1_instAddr_i  in  ADDR_W  way1 fetch address
way1_dataOk_o  out  1  one-cycle pulse for way1
way1_inst_o  out  DATA_W  fetched instruction for way1
jumpFlag_i  in  1  pipeline redirect; flushes the in-flight fetch
mem_request_o  out  1  memory fetch request; held until mem_dataOk_i
mem_instAddr_o  out  ADDR_W  memory fetch address
mem_dataOk_i  in  1  memory response valid
mem_inst_i  in  DATA_W  memory response data
busy_o  out  1  high in any state other than IDLE
timeout_o  out  1  watchdog pulse; tied 0 when the feature is compiled out

Behaviour:
- Reset: the following are all 0 and stay 0 until reset is released:
  - outputs: dataOk, inst, mem_request_o, mem_instAddr_o, busy_o, timeout_o
  - internal: timeout counter; state = IDLE.
- Reset: lastGrant = 1, so way0 wins the first tie. Reset mid-transaction abandons it; a later stray mem_dataOk_i in IDLE is ignored.
- States:
  - IDLE: no transaction.
  - BUSY: transaction in flight; grantWay register records which way owns it.
  - DRAIN: flushed transaction; waiting for the memory response to discard it.
- IDLE, jumpFlag_i low: eligible request = wayX_request_i high AND wayX_dataOk_o low (requester still dropping).
  - If exactly one way is eligible, grant it.
  - If both are eligible, grant the way opposite lastGrant.
  - On grant, at the next edge: register the address into mem_instAddr_o, set mem_request_o = 1, set grantWay and lastGrant, go to BUSY.
  - Latency: request seen at cycle N, mem_request_o high at cycle N+1.
- IDLE, jumpFlag_i high: no grant this cycle.
- BUSY, on mem_dataOk_i:
  - At the next edge: mem_request_o = 0, wayG_inst_o = mem_inst_i, wayG_dataOk_o = 1 for one cycle, go to IDLE.
  - Response latency: one cycle after mem_dataOk_i.
  - A new grant is possible in the cycle where dataOk_o is high (for the other way only).
- BUSY, jumpFlag_i high and mem_dataOk_i low: go to DRAIN. mem_request_o stays high (bus protocol forbids withdrawal).
- BUSY, jumpFlag_i and mem_dataOk_i high in the same cycle: response discarded, no dataOk_o, go to IDLE.
- DRAIN:
  - On mem_dataOk_i: mem_request_o = 0, go to IDLE, no dataOk_o.
  - jumpFlag_i is ignored in DRAIN.
- wayX_inst_o holds its last value between pulses. The dataOk_o outputs are never both high.
- Round-robin fairness: with both ways requesting continuously, grants alternate strictly.

Optional Feature:
- Macro: FETCH_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY/DRAIN and increments each cycle there, saturating.
  - When the count reaches TIMEOUT_CYCLES-1 with no mem_dataOk_i:
    - next edge: timeout_o pulses for one cycle, mem_request_o = 0, go to IDLE, no dataOk_o;
    - a late mem_dataOk_i arriving afterwards in IDLE is ignored.
  - mem_dataOk_i in the same cycle as the limit wins; the timeout does not fire.
- Undefined: no counter; timeout_o is constant 0; BUSY/DRAIN wait indefinitely.

Decomposition:
- Package fetch_arb_pkg:
  - state enum {IDLE, BUSY, DRAIN};
  - way-ID constants WAY0 = 1'b0, WAY1 = 1'b1;
  - default TIMEOUT_CYCLES.
- One sub-module: fetch_arb_watchdog (counter plus limit compare, instantiated only under FETCH_ARB_TIMEOUT_EN).
- The round-robin pick stays inline.

Test Plan:
- Reset, then way0 requests 0x0000_0100, memory answers 3 cycles after mem_request_o with 0x0010_0093 -> mem_instAddr_o = 0x100; way0_dataOk_o pulses for 1 cycle one cycle after mem_dataOk_i, with way0_inst_o = 0x0010_0093; way1_dataOk_o stays 0.
- Both ways request continuously (way0 at 0x200, way1 at 0x400) with 1-cycle memory -> first grant to way0, then strict alternation way1, way0, way1; no consecutive duplicates.
- Way1 is in BUSY and jumpFlag_i pulses 1 cycle before mem_dataOk_i -> state goes to DRAIN; mem_request_o stays high until dataOk; no way1_dataOk_o; busy_o drops the cycle after dataOk.
- jumpFlag_i coincides with mem_dataOk_i in BUSY -> no dataOk_o, IDLE next cycle. jumpFlag_i in IDLE with way0 requesting -> grant delayed by exactly 1 cycle.
- reset asserted asynchronously mid-BUSY -> all outputs 0 immediately. A stray mem_dataOk_i after reset is released -> no dataOk_o.
- With FETCH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, memory never responds -> timeout_o pulses once about 8 cycles after mem_request_o rose, mem_request_o drops, the next request is granted normally.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared types and constants for the two-way instruction fetch arbiter.
package fetch_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   localparam logic WAY0 = 1'b0;
   localparam logic WAY1 = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fetch_arb_watchdog.sv
// Cycle counter for an in-flight fetch; flags the last allowed cycle so the arbiter can abandon it.
module fetch_arb_watchdog
   import fetch_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic active_i,
   output logic limit_o
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Saturating so a transaction held past the limit never wraps back below it.
   always_comb begin
      count_d = count_q;
      if (start_i) begin
         count_d = '0;
      end else if (active_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign limit_o = active_i && (count_q == LIMIT);

endmodule

// File: rtl/inst_fetch_arbiter.sv
// Round-robin share of one instruction-memory port between two IFUs, one fetch outstanding, jump-flush via DRAIN.
// Optional watchdog abort is compiled in with FETCH_ARB_TIMEOUT_EN.
module inst_fetch_arbiter
   import fetch_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              way0_request_i,
   input  logic [ADDR_W-1:0] way0_instAddr_i,
   output logic              way0_dataOk_o,
   output logic [DATA_W-1:0] way0_inst_o,
   input  logic              way1_request_i,
   input  logic [ADDR_W-1:0] way1_instAddr_i,
   output logic              way1_dataOk_o,
   output logic [DATA_W-1:0] way1_inst_o,
   input  logic              jumpFlag_i,
   output logic              mem_request_o,
   output logic [ADDR_W-1:0] mem_instAddr_o,
   input  logic              mem_dataOk_i,
   input  logic [DATA_W-1:0] mem_inst_i,
   output logic              busy_o,
   output logic              timeout_o
);

   arb_state_e        state_q, state_d;
   logic              grant_way_q, grant_way_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              way0_ok_q, way0_ok_d;
   logic              way1_ok_q, way1_ok_d;
   logic [DATA_W-1:0] way0_inst_q, way0_inst_d;
   logic [DATA_W-1:0] way1_inst_q, way1_inst_d;
   logic              timeout_q, timeout_d;
   logic              busy_w, limit_w;
   logic              elig0_w, elig1_w;

   // A way whose response is being returned this cycle is still lowering its request.
   assign elig0_w = way0_request_i && !way0_ok_q;
   assign elig1_w = way1_request_i && !way1_ok_q;
   assign busy_w  = (state_q != IDLE);

`ifdef FETCH_ARB_TIMEOUT_EN
   logic wd_start_w;

   assign wd_start_w = (state_d != state_q) && (state_d != IDLE);

   fetch_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .start_i  (wd_start_w),
      .active_i (busy_w),
      .limit_o  (limit_w)
   );
`else
   localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
   assign limit_w = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_way_d  = grant_way_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      way0_ok_d    = 1'b0;
      way1_ok_d    = 1'b0;
      way0_inst_d  = way0_inst_q;
      way1_inst_d  = way1_inst_q;
      timeout_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!jumpFlag_i && (elig0_w || elig1_w)) begin
               if (elig0_w && elig1_w) begin
                  grant_way_d = ~last_grant_q;
               end else begin
                  grant_way_d = elig0_w ? WAY0 : WAY1;
               end
               last_grant_d = grant_way_d;
               mem_addr_d   = (grant_way_d == WAY0) ? way0_instAddr_i : way1_instAddr_i;
               mem_req_d    = 1'b1;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (mem_dataOk_i) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
               // A jump in the response cycle still discards the data.
               if (!jumpFlag_i) begin
                  if (grant_way_q == WAY0) begin
                     way0_ok_d   = 1'b1;
                     way0_inst_d = mem_inst_i;
                  end else begin
                     way1_ok_d   = 1'b1;
                     way1_inst_d = mem_inst_i;
                  end
               end
            end else if (limit_w) begin
               timeout_d = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (jumpFlag_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_dataOk_i) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (limit_w) begin
               timeout_d = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_way_q  <= WAY0;
         last_grant_q <= WAY1;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         way0_ok_q    <= 1'b0;
         way1_ok_q    <= 1'b0;
         way0_inst_q  <= '0;
         way1_inst_q  <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_way_q  <= grant_way_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         way0_ok_q    <= way0_ok_d;
         way1_ok_q    <= way1_ok_d;
         way0_inst_q  <= way0_inst_d;
         way1_inst_q  <= way1_inst_d;
         timeout_q    <= timeout_d;
      end
   end

   assign way0_dataOk_o  = way0_ok_q;
   assign way0_inst_o    = way0_inst_q;
   assign way1_dataOk_o  = way1_ok_q;
   assign way1_inst_o    = way1_inst_q;
   assign mem_request_o  = mem_req_q;
   assign mem_instAddr_o = mem_addr_q;
   assign busy_o         = busy_w;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Bench for inst_fetch_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_inst_fetch_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int TB_TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              way0_request_i, way1_request_i;
   logic [ADDR_W-1:0] way0_instAddr_i, way1_instAddr_i;
   logic              way0_dataOk_o, way1_dataOk_o;
   logic [DATA_W-1:0] way0_inst_o, way1_inst_o;
   logic              jumpFlag_i;
   logic              mem_request_o;
   logic [ADDR_W-1:0] mem_instAddr_o;
   logic              mem_dataOk_i;
   logic [DATA_W-1:0] mem_inst_i;
   logic              busy_o, timeout_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inst_fetch_arbiter #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .way0_request_i  (way0_request_i),
      .way0_instAddr_i (way0_instAddr_i),
      .way0_dataOk_o   (way0_dataOk_o),
      .way0_inst_o     (way0_inst_o),
      .way1_request_i  (way1_request_i),
      .way1_instAddr_i (way1_instAddr_i),
      .way1_dataOk_o   (way1_dataOk_o),
      .way1_inst_o     (way1_inst_o),
      .jumpFlag_i      (jumpFlag_i),
      .mem_request_o   (mem_request_o),
      .mem_instAddr_o  (mem_instAddr_o),
      .mem_dataOk_i    (mem_dataOk_i),
      .mem_inst_i      (mem_inst_i),
      .busy_o          (busy_o),
      .timeout_o       (timeout_o)
   );

   task automatic drive_idle();
      way0_request_i  = 1'b0;
      way0_instAddr_i = '0;
      way1_request_i  = 1'b0;
      way1_instAddr_i = '0;
      jumpFlag_i      = 1'b0;
      mem_dataOk_i    = 1'b0;
      mem_inst_i      = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      way0_request_i  = 1'b1;
      way0_instAddr_i = 32'h0000_0100;
      repeat (3) @(negedge clk);
      checks++;
      if ({way0_dataOk_o, way1_dataOk_o, mem_request_o, busy_o, timeout_o} !== 5'b0 ||
          way0_inst_o !== '0 || way1_inst_o !== '0 || mem_instAddr_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got ok=%b%b req=%b busy=%b to=%b inst0=%h inst1=%h addr=%h, required all 0",
                  way0_dataOk_o, way1_dataOk_o, mem_request_o, busy_o, timeout_o, way0_inst_o, way1_inst_o, mem_instAddr_o);
      end
      way0_request_i = 1'b0;
      reset          = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: got req=%b busy=%b, required 0 0", mem_request_o, busy_o);
      end
   endtask

   task automatic test_single_fetch();
      way0_request_i  = 1'b1;
      way0_instAddr_i = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1 || mem_instAddr_o !== 32'h0000_0100 || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL single_grant: got req=%b addr=%h busy=%b, required 1 00000100 1", mem_request_o, mem_instAddr_o, busy_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_request_o !== 1'b1 || way0_dataOk_o !== 1'b0 || way1_dataOk_o !== 1'b0) begin
            failures++;
            $display("FAIL single_wait: got req=%b ok=%b%b, required req=1 ok=00", mem_request_o, way0_dataOk_o, way1_dataOk_o);
         end
      end
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'h0010_0093;
      @(negedge clk);
      checks++;
      if (way0_dataOk_o !== 1'b1 || way0_inst_o !== 32'h0010_0093 || way1_dataOk_o !== 1'b0 || mem_request_o !== 1'b0) begin
         failures++;
         $display("FAIL single_resp: got ok0=%b inst0=%h ok1=%b req=%b, required 1 00100093 0 0",
                  way0_dataOk_o, way0_inst_o, way1_dataOk_o, mem_request_o);
      end
      mem_dataOk_i   = 1'b0;
      mem_inst_i     = '0;
      way0_request_i = 1'b0;
      @(negedge clk);
      checks++;
      if (way0_dataOk_o !== 1'b0 || way0_inst_o !== 32'h0010_0093 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL single_hold: got ok0=%b inst0=%h busy=%b, required 0 00100093 0", way0_dataOk_o, way0_inst_o, busy_o);
      end
   endtask

   task automatic test_round_robin();
      logic          exp_way;
      logic [31:0]   data;
      do_reset();
      way0_request_i  = 1'b1;
      way0_instAddr_i = 32'h0000_0200;
      way1_request_i  = 1'b1;
      way1_instAddr_i = 32'h0000_0400;
      exp_way = 1'b0;
      for (int g = 0; g < 4; g++) begin
         int waited;
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (!mem_request_o && waited < 4);
         checks++;
         if (mem_request_o !== 1'b1 || mem_instAddr_o !== (exp_way ? 32'h0000_0400 : 32'h0000_0200)) begin
            failures++;
            $display("FAIL rr_grant%0d: got req=%b addr=%h, required req=1 way%0d", g, mem_request_o, mem_instAddr_o, exp_way);
         end
         data         = $urandom;
         mem_dataOk_i = 1'b1;
         mem_inst_i   = data;
         @(negedge clk);
         mem_dataOk_i = 1'b0;
         checks++;
         if ({way1_dataOk_o, way0_dataOk_o} !== (exp_way ? 2'b10 : 2'b01) ||
             (exp_way ? way1_inst_o : way0_inst_o) !== data) begin
            failures++;
            $display("FAIL rr_resp%0d: got ok=%b%b inst0=%h inst1=%h, required way%0d data %h",
                     g, way1_dataOk_o, way0_dataOk_o, way0_inst_o, way1_inst_o, exp_way, data);
         end
         if (g == 3) drive_idle();
         exp_way = ~exp_way;
      end
      @(negedge clk);
   endtask

   task automatic test_drain();
      way1_request_i  = 1'b1;
      way1_instAddr_i = 32'h0000_0300;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1 || mem_instAddr_o !== 32'h0000_0300) begin
         failures++;
         $display("FAIL drain_grant: got req=%b addr=%h, required 1 00000300", mem_request_o, mem_instAddr_o);
      end
      jumpFlag_i = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1 || busy_o !== 1'b1 || way1_dataOk_o !== 1'b0) begin
         failures++;
         $display("FAIL drain_hold: got req=%b busy=%b ok1=%b, required 1 1 0", mem_request_o, busy_o, way1_dataOk_o);
      end
      jumpFlag_i   = 1'b0;
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b0 || busy_o !== 1'b0 || way1_dataOk_o !== 1'b0 || way0_dataOk_o !== 1'b0) begin
         failures++;
         $display("FAIL drain_discard: got req=%b busy=%b ok=%b%b, required 0 0 00", mem_request_o, busy_o, way1_dataOk_o, way0_dataOk_o);
      end
      drive_idle();
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b0 || way1_dataOk_o !== 1'b0 || way1_inst_o === 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL drain_after: got req=%b ok1=%b inst1=%h, required 0 0 and not deadbeef", mem_request_o, way1_dataOk_o, way1_inst_o);
      end
   endtask

   task automatic test_jump_coincident();
      way0_request_i  = 1'b1;
      way0_instAddr_i = 32'h0000_0500;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1) begin
         failures++;
         $display("FAIL coinc_grant: got req=%b, required 1", mem_request_o);
      end
      jumpFlag_i   = 1'b1;
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'h1111_2222;
      @(negedge clk);
      checks++;
      if (way0_dataOk_o !== 1'b0 || way1_dataOk_o !== 1'b0 || mem_request_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL coinc_discard: got ok=%b%b req=%b busy=%b, required 00 0 0", way1_dataOk_o, way0_dataOk_o, mem_request_o, busy_o);
      end
      mem_dataOk_i = 1'b0;
      jumpFlag_i   = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_jump_block: got req=%b, required 0", mem_request_o);
      end
      jumpFlag_i = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1 || mem_instAddr_o !== 32'h0000_0500) begin
         failures++;
         $display("FAIL idle_jump_delay: got req=%b addr=%h, required 1 00000500", mem_request_o, mem_instAddr_o);
      end
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'h3333_4444;
      @(negedge clk);
      checks++;
      if (way0_dataOk_o !== 1'b1 || way0_inst_o !== 32'h3333_4444) begin
         failures++;
         $display("FAIL idle_jump_resp: got ok0=%b inst0=%h, required 1 33334444", way0_dataOk_o, way0_inst_o);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      way1_request_i  = 1'b1;
      way1_instAddr_i = 32'h0000_0600;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1) begin
         failures++;
         $display("FAIL areset_grant: got req=%b, required 1", mem_request_o);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({way0_dataOk_o, way1_dataOk_o, mem_request_o, busy_o, timeout_o} !== 5'b0 ||
          way0_inst_o !== '0 || way1_inst_o !== '0 || mem_instAddr_o !== '0) begin
         failures++;
         $display("FAIL areset_immediate: got ok=%b%b req=%b busy=%b inst0=%h addr=%h, required all 0",
                  way0_dataOk_o, way1_dataOk_o, mem_request_o, busy_o, way0_inst_o, mem_instAddr_o);
      end
      way1_request_i = 1'b0;
      repeat (2) @(negedge clk);
      reset        = 1'b0;
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'h5555_6666;
      @(negedge clk);
      checks++;
      if (way0_dataOk_o !== 1'b0 || way1_dataOk_o !== 1'b0 || mem_request_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL stray_resp: got ok=%b%b req=%b busy=%b, required 00 0 0", way1_dataOk_o, way0_dataOk_o, mem_request_o, busy_o);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      way1_request_i  = 1'b1;
      way1_instAddr_i = 32'h0000_0700;
      @(negedge clk);
      checks++;
      if (mem_request_o !== 1'b1) begin
         failures++;
         $display("FAIL to_grant: got req=%b, required 1", mem_request_o);
      end
`ifdef FETCH_ARB_TIMEOUT_EN
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout_o && n < 20);
      checks++;
      if (timeout_o !== 1'b1 || n != TB_TIMEOUT || mem_request_o !== 1'b0 || way1_dataOk_o !== 1'b0) begin
         failures++;
         $display("FAIL to_fire: got to=%b after %0d cycles req=%b ok1=%b, required 1 after %0d, req 0 ok1 0",
                  timeout_o, n, mem_request_o, way1_dataOk_o, TB_TIMEOUT);
      end
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b0 || mem_request_o !== 1'b1) begin
         failures++;
         $display("FAIL to_regrant: got to=%b req=%b, required 0 1", timeout_o, mem_request_o);
      end
`else
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (timeout_o !== 1'b0 || mem_request_o !== 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL to_disabled: got %0d cycles with timeout_o set or request dropped, required 0", n);
      end
`endif
      mem_dataOk_i = 1'b1;
      mem_inst_i   = 32'h7777_8888;
      @(negedge clk);
      checks++;
      if (way1_dataOk_o !== 1'b1 || way1_inst_o !== 32'h7777_8888) begin
         failures++;
         $display("FAIL to_resp: got ok1=%b inst1=%h, required 1 77778888", way1_dataOk_o, way1_inst_o);
      end
      drive_idle();
      @(negedge clk);
   endtask

   // Transaction-level model: grants follow the eligibility/round-robin rule, memory answers
   // with random latency, and a fetch is dropped if a jump is seen at any point while it is in flight.
   task automatic test_random(input int cycles);
      logic              req [2];
      logic [ADDR_W-1:0] req_addr [2];
      logic [ADDR_W-1:0] prev_addr [2];
      logic [ADDR_W-1:0] tmp;
      logic [DATA_W-1:0] prev_mdata;
      logic              prev_mreq, prev_jump, prev_mdok;
      logic [1:0]        prev_elig, exp_ok, obs_ok;
      logic              last, owner, flushed, exp_mreq, jmp, mdok;
      int                lat, bad_req, bad_ok, bad_data, bad_addr;
      do_reset();
      for (int w = 0; w < 2; w++) begin
         req[w] = 1'b0; req_addr[w] = '0; prev_addr[w] = '0;
      end
      prev_mdata = '0; prev_mreq = 1'b0; prev_jump = 1'b0; prev_mdok = 1'b0; prev_elig = 2'b00;
      last = 1'b1; owner = 1'b0; flushed = 1'b0; lat = 0;
      bad_req = 0; bad_ok = 0; bad_data = 0; bad_addr = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         obs_ok = {way1_dataOk_o, way0_dataOk_o};
         exp_ok = 2'b00;
         if (!prev_mreq) begin
            exp_mreq = !prev_jump && (prev_elig != 2'b00);
            if (exp_mreq) begin
               owner   = (prev_elig == 2'b11) ? ~last : prev_elig[1];
               last    = owner;
               flushed = 1'b0;
               lat     = $urandom_range(0, 4);
               checks++;
               if (mem_instAddr_o !== prev_addr[owner]) begin
                  failures++;
                  if (bad_addr++ < 5) $display("FAIL rand_addr cyc %0d: got %h, required %h (way%0d)", c, mem_instAddr_o, prev_addr[owner], owner);
               end
            end
         end else begin
            exp_mreq = !prev_mdok;
            if (prev_mdok && !flushed) exp_ok[owner] = 1'b1;
         end
         checks++;
         if (mem_request_o !== exp_mreq || busy_o !== exp_mreq) begin
            failures++;
            if (bad_req++ < 5) $display("FAIL rand_req cyc %0d: got req=%b busy=%b, required %b", c, mem_request_o, busy_o, exp_mreq);
         end
         checks++;
         if (obs_ok !== exp_ok) begin
            failures++;
            if (bad_ok++ < 5) $display("FAIL rand_ok cyc %0d: got %b, required %b", c, obs_ok, exp_ok);
         end
         if (exp_ok != 2'b00) begin
            checks++;
            if ((exp_ok[0] ? way0_inst_o : way1_inst_o) !== prev_mdata) begin
               failures++;
               if (bad_data++ < 5) $display("FAIL rand_data cyc %0d: got %h/%h, required %h", c, way0_inst_o, way1_inst_o, prev_mdata);
            end
         end
         for (int w = 0; w < 2; w++) begin
            if (obs_ok[w]) begin
               req[w] = 1'b0;
            end else if (!req[w] && $urandom_range(0, 2) == 0) begin
               tmp         = $urandom;
               tmp[31]     = (w == 1);
               tmp[1:0]    = 2'b00;
               req[w]      = 1'b1;
               req_addr[w] = tmp;
            end
         end
         jmp  = ($urandom_range(0, 9) == 0);
         mdok = 1'b0;
         if (mem_request_o) begin
            if (lat == 0) begin
               mdok       = 1'b1;
               prev_mdata = $urandom;
            end else begin
               lat--;
            end
            if (jmp) flushed = 1'b1;
         end
         way0_request_i  = req[0];
         way0_instAddr_i = req_addr[0];
         way1_request_i  = req[1];
         way1_instAddr_i = req_addr[1];
         jumpFlag_i      = jmp;
         mem_dataOk_i    = mdok;
         mem_inst_i      = prev_mdata;
         prev_mreq = mem_request_o;
         prev_jump = jmp;
         prev_mdok = mdok;
         prev_elig = {req[1] && !obs_ok[1], req[0] && !obs_ok[0]};
         prev_addr[0] = req_addr[0];
         prev_addr[1] = req_addr[1];
      end
      way0_request_i = 1'b0;
      way1_request_i = 1'b0;
      jumpFlag_i     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mem_dataOk_i = mem_request_o;
      end
      checks++;
      if (mem_request_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL rand_quiesce: got req=%b busy=%b, required 0 0", mem_request_o, busy_o);
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_round_robin();
      test_drain();
      test_jump_coincident();
      test_async_reset();
      test_timeout();
      test_random(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL tb_time_limit: simulation did not complete within 200000 time units");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

endmodule
